ysyx_220066_wb_arbiter: RTL and testbench

Parametrised write-back stage that merges the main pipeline result channel with NCH-1 long-latency result channels (multiplier, divider, ...) into the single register-file write port and commit stream. Channel 0, the main pipeline, is a single registered stage that can select load data from memory. Channels 1..NCH-1 are buffered in per-channel FIFOs and arbitrated round-robin. A starvation limiter briefly back-pressures channel 0 so buffered channels always drain.

---
 rtl/ysyx_220066_pkg.sv | 12 +
 rtl/ysyx_220066_wb_arbiter_if.sv | 23 ++
 rtl/ysyx_220066_wb_fifo.sv | 35 +++
 rtl/ysyx_220066_wb_arbiter.sv | 85 ++++++++
 tb/tb_ysyx_220066_wb_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_220066_pkg.sv
// ysyx_220066_pkg: shared register-index width, default data width and write-back entry type
package ysyx_220066_pkg;
    localparam int RW = 5;
    localparam int XLEN = 64;
    typedef struct packed {
        logic            wen;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
        logic            err;
    } wb_entry_t;
endpackage

// File: rtl/ysyx_220066_wb_arbiter_if.sv
// ysyx_220066_wb_arbiter_if: result channels in, register-file write port and commit stream out
interface ysyx_220066_wb_arbiter_if #(
    parameter int NCH  = 3,
    parameter int XLEN = 64
);
    logic [NCH-1:0]         in_valid, in_ready, in_wen, in_error;
    logic [5*NCH-1:0]       in_rd;
    logic [XLEN*NCH-1:0]    in_data, in_pc;
    logic                   in_memrd, mem_error;
    logic [XLEN-1:0]        mem_data;
    logic                   rf_wen, commit_valid, commit_error;
    logic [4:0]             rf_rd;
    logic [XLEN-1:0]        rf_data, commit_pc;
    logic [$clog2(NCH)-1:0] commit_ch;
    modport master (
        output in_valid, in_rd, in_wen, in_data, in_pc, in_error, in_memrd, mem_data, mem_error,
        input  in_ready, rf_wen, rf_rd, rf_data, commit_valid, commit_pc, commit_error, commit_ch
    );
    modport slave (
        input  in_valid, in_rd, in_wen, in_data, in_pc, in_error, in_memrd, mem_data, mem_error,
        output in_ready, rf_wen, rf_rd, rf_data, commit_valid, commit_pc, commit_error, commit_ch
    );
endinterface

// File: rtl/ysyx_220066_wb_fifo.sv
// ysyx_220066_wb_fifo: per-channel result buffer; head is visible combinationally
module ysyx_220066_wb_fifo
    import ysyx_220066_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = wb_entry_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     head,
    output logic empty,
    output logic full
);
    localparam int AW = $clog2(DEPTH);
    T mem [DEPTH];
    logic [AW:0] wp, rp;
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) begin
                mem[wp[AW-1:0]] <= din;
                wp <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
        end
    end
    assign head  = mem[rp[AW-1:0]];
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
endmodule

// File: rtl/ysyx_220066_wb_arbiter.sv
// ysyx_220066_wb_arbiter: merges the main pipeline result with buffered long-latency results
// into one register-file write and commit per cycle, round-robin over the buffered channels.
module ysyx_220066_wb_arbiter
    import ysyx_220066_pkg::*;
#(
    parameter int NCH    = 3,
    parameter int XLEN   = ysyx_220066_pkg::XLEN,
    parameter int DEPTH  = 2,
    parameter int STARVE = 4
) (
    input logic clk,
    input logic rst,
    ysyx_220066_wb_arbiter_if.slave bus
);
    localparam int CW = $clog2(NCH);
    localparam int SW = $clog2(STARVE + 1);
    typedef struct packed {
        logic            wen;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
        logic            err;
    } entry_t;
    entry_t in_e [NCH];
    entry_t head [NCH];
    entry_t s0, g;
    logic v0, m0, any, fgnt, cv, ld, err;
    logic [NCH-1:0] push, ne;
    logic [NCH-1:1] empty, full;
    logic [CW-1:0] rr, sel, cand, gnt;
    logic [SW-1:0] cnt;
    for (genvar c = 0; c < NCH; c++) begin : g_in
        assign in_e[c] = {bus.in_wen[c], bus.in_rd[5*c +: 5], bus.in_data[XLEN*c +: XLEN],
                          bus.in_pc[XLEN*c +: XLEN], bus.in_error[c]};
    end
    for (genvar i = 1; i < NCH; i++) begin : g_fifo
        ysyx_220066_wb_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
            .clk(clk), .rst(rst), .push(push[i]), .pop(fgnt && sel == CW'(i)),
            .din(in_e[i]), .head(head[i]), .empty(empty[i]), .full(full[i])
        );
    end
    assign head[0] = s0;
    assign push    = bus.in_valid & bus.in_ready;
    assign ne      = {~empty, 1'b0};
    assign any     = |ne;
    // Scan downwards so the first non-empty channel at or after rr wins.
    always_comb begin
        sel  = rr;
        cand = rr;
        for (int k = NCH - 2; k >= 0; k--) begin
            cand = CW'(1 + (int'(rr) - 1 + k) % (NCH - 1));
            if (ne[cand]) sel = cand;
        end
    end
    assign fgnt = !v0 && any;
    assign gnt  = v0 ? '0 : sel;
    assign g    = head[gnt];
    assign cv   = rst && (v0 || any);
    assign ld   = v0 && m0;
    assign err  = cv && (g.err || (ld && bus.mem_error));
    assign bus.commit_valid = cv;
    assign bus.commit_error = err;
    assign bus.commit_ch    = cv ? gnt : '0;
    assign bus.commit_pc    = cv ? g.pc : '0;
    assign bus.rf_rd        = cv ? g.rd : '0;
    assign bus.rf_data      = cv ? (ld ? bus.mem_data : g.data) : '0;
    assign bus.rf_wen       = cv && g.wen && !err && g.rd != '0;
    assign bus.in_ready     = rst ? {~full, cnt < SW'(STARVE)} : '0;
    // The hold cycle itself clears cnt: the next cycle is a guaranteed buffered grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v0  <= 1'b0;
            rr  <= CW'(1);
            cnt <= '0;
        end else begin
            v0 <= push[0];
            if (push[0]) begin
                s0 <= in_e[0];
                m0 <= bus.in_memrd;
            end
            if (fgnt) rr <= (sel == CW'(NCH - 1)) ? CW'(1) : sel + CW'(1);
            cnt <= (fgnt || !any || cnt == SW'(STARVE)) ? '0 : cnt + SW'(v0);
        end
    end
endmodule

// File: tb/tb_ysyx_220066_wb_arbiter.sv
// tb_ysyx_220066_wb_arbiter: directed stimulus; a queue-based reference model is compared
// against every cycle, plus hand-computed expectations at key points.
module tb_ysyx_220066_wb_arbiter;
    localparam int NCH = 3, XLEN = 64, DEPTH = 2, STARVE = 4;
    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] data, pc;
        logic        err, memrd;
    } ent_t;
    logic clk = 1'b0, rst = 1'b0;
    int n_chk = 0, n_fail = 0;
    ysyx_220066_wb_arbiter_if #(.NCH(NCH), .XLEN(XLEN)) bus ();
    ysyx_220066_wb_arbiter #(.NCH(NCH), .XLEN(XLEN), .DEPTH(DEPTH), .STARVE(STARVE)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    initial forever #5 clk = ~clk;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    // Reference model: stage-0 slot, one queue per buffered channel, rotating start pointer,
    // count of consecutive cycles a buffered result lost to stage 0.
    bit   mv0 = 0;
    ent_t ms0, e, ne;
    ent_t q [NCH][$];
    int   mrr = 1, lost = 0, g;
    logic [NCH-1:0] er;
    logic ecv, eerr, ld, ewen, anyq;
    logic [63:0] ed;
    initial forever begin
        @(negedge clk);
        e = '{default: 0};
        g = -1;
        if (mv0) begin
            g = 0;
            e = ms0;
        end else
            for (int k = 0; k < NCH - 1; k++)
                if (g < 0 && q[1 + (mrr - 1 + k) % (NCH - 1)].size() > 0) begin
                    g = 1 + (mrr - 1 + k) % (NCH - 1);
                    e = q[g][0];
                end
        ecv  = rst && g >= 0;
        ld   = g == 0 && e.memrd;
        eerr = ecv && (e.err || (ld && bus.mem_error));
        ed   = ld ? bus.mem_data : e.data;
        ewen = ecv && e.wen && !eerr && e.rd != 0;
        er[0] = rst && lost < STARVE;
        for (int i = 1; i < NCH; i++) er[i] = rst && q[i].size() < DEPTH;
        chk("commit_valid", bus.commit_valid, ecv);
        chk("in_ready", bus.in_ready, er);
        chk("rf_wen", bus.rf_wen, ewen);
        if (ecv || !rst) begin
            chk("commit_ch", bus.commit_ch, ecv ? g : 0);
            chk("commit_pc", bus.commit_pc, ecv ? e.pc : 0);
            chk("commit_error", bus.commit_error, eerr);
            chk("rf_rd", bus.rf_rd, ecv ? e.rd : 0);
            chk("rf_data", bus.rf_data, ecv ? ed : 0);
        end
        if (!rst) begin
            mv0 = 0;
            mrr = 1;
            lost = 0;
            for (int i = 0; i < NCH; i++) q[i].delete();
        end else begin
            anyq = 0;
            for (int i = 1; i < NCH; i++) anyq |= q[i].size() > 0;
            lost = (g > 0 || !anyq || lost == STARVE) ? 0 : lost + int'(mv0);
            if (g > 0) begin
                void'(q[g].pop_front());
                mrr = g == NCH - 1 ? 1 : g + 1;
            end
            for (int i = 0; i < NCH; i++) begin
                ne.wen   = bus.in_wen[i];
                ne.rd    = bus.in_rd[5*i +: 5];
                ne.data  = bus.in_data[64*i +: 64];
                ne.pc    = bus.in_pc[64*i +: 64];
                ne.err   = bus.in_error[i];
                ne.memrd = i == 0 && bus.in_memrd;
                if (i == 0) begin
                    mv0 = bus.in_valid[0] && er[0];
                    if (mv0) ms0 = ne;
                end else if (bus.in_valid[i] && er[i]) q[i].push_back(ne);
            end
        end
    end
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.in_valid  = '0;
        bus.in_memrd  = 1'b0;
        bus.mem_error = 1'b0;
        bus.mem_data  = '0;
    endtask
    task automatic drv(input int c, input logic [4:0] rd, input logic wen,
                       input logic [63:0] data, input logic [63:0] pc, input logic err);
        bus.in_valid[c]          = 1'b1;
        bus.in_rd[5*c +: 5]      = rd;
        bus.in_wen[c]            = wen;
        bus.in_data[64*c +: 64]  = data;
        bus.in_pc[64*c +: 64]    = pc;
        bus.in_error[c]          = err;
    endtask
    initial begin
        bus.in_rd = '0; bus.in_wen = '0; bus.in_data = '0; bus.in_pc = '0; bus.in_error = '0;
        idle();
        nxt(); nxt();
        @(negedge clk);
        chk("reset_valid", bus.commit_valid, 0);
        chk("reset_ready", bus.in_ready, 0);
        nxt();
        rst = 1'b1;
        // load from memory, then the same load faulting
        drv(0, 5, 1, 64'h1111, 64'h80000004, 0); bus.in_memrd = 1'b1;
        nxt(); idle(); bus.mem_data = 64'hDEAD;
        @(negedge clk);
        chk("load_wen", bus.rf_wen, 1);
        chk("load_rd", bus.rf_rd, 5);
        chk("load_data", bus.rf_data, 64'hDEAD);
        chk("load_ch", bus.commit_ch, 0);
        chk("load_pc", bus.commit_pc, 64'h80000004);
        nxt();
        drv(0, 5, 1, 64'h1111, 64'h80000004, 0); bus.in_memrd = 1'b1;
        nxt(); idle(); bus.mem_data = 64'hBEEF; bus.mem_error = 1'b1;
        @(negedge clk);
        chk("load_fault_err", bus.commit_error, 1);
        chk("load_fault_wen", bus.rf_wen, 0);
        nxt(); idle();
        // rd=0 still commits; upstream fault suppresses the write
        drv(0, 0, 1, 64'h42, 64'h100, 0);
        nxt(); idle();
        @(negedge clk);
        chk("rd0_valid", bus.commit_valid, 1);
        chk("rd0_wen", bus.rf_wen, 0);
        nxt();
        drv(0, 7, 1, 64'h43, 64'h104, 1);
        nxt(); idle();
        @(negedge clk);
        chk("err_error", bus.commit_error, 1);
        chk("err_wen", bus.rf_wen, 0);
        nxt();
        bus.in_error = '0;
        // round-robin between buffered channels, twice to exercise the wrap
        for (int r = 0; r < 2; r++) begin
            drv(1, 3, 1, 64'h300 + r, 64'h200, 0);
            drv(2, 4, 1, 64'h400 + r, 64'h204, 0);
            nxt(); idle();
            @(negedge clk);
            chk("rr_first_ch", bus.commit_ch, 1);
            chk("rr_first_rd", bus.rf_rd, 3);
            nxt();
            @(negedge clk);
            chk("rr_second_ch", bus.commit_ch, 2);
            chk("rr_second_rd", bus.rf_rd, 4);
            nxt();
            @(negedge clk);
            chk("rr_idle", bus.commit_valid, 0);
            nxt();
        end
        // starvation: channel 0 every cycle, one entry waiting in channel 1
        drv(1, 9, 1, 64'h900, 64'h300, 0);
        drv(0, 10, 1, 64'ha00, 64'h400, 0);
        nxt();
        for (int k = 1; k <= 7; k++) begin
            idle();
            drv(0, 10, 1, 64'ha00 + k, 64'h400 + 4 * k, 0);
            @(negedge clk);
            if (k == 4) chk("starve_pre_ready", bus.in_ready[0], 1);
            if (k == 5) chk("starve_hold", bus.in_ready[0], 0);
            if (k == 6) begin
                chk("starve_fifo_ch", bus.commit_ch, 1);
                chk("starve_fifo_rd", bus.rf_rd, 9);
                chk("starve_ready_back", bus.in_ready[0], 1);
            end
            if (k == 7) begin
                chk("starve_resume_valid", bus.commit_valid, 1);
                chk("starve_resume_ch", bus.commit_ch, 0);
            end
            nxt();
        end
        idle(); nxt(); nxt();
        // fill channel 2 past its depth while channel 0 competes, then drain in order
        for (int k = 0; k <= 7; k++) begin
            idle();
            if (k <= 2) drv(0, 11, 1, 64'hb00 + k, 64'h500 + 4 * k, 0);
            if (k <= 5) drv(2, 5'd20 + 5'(k > 2 ? 2 : k), 1, 64'hc00 + k, 64'h600, 0);
            @(negedge clk);
            if (k == 2 || k == 4) chk("full_blocked", bus.in_ready[2], 0);
            if (k >= 4 && k <= 6) begin
                chk("drain_ch", bus.commit_ch, 2);
                chk("drain_rd", bus.rf_rd, 20 + k - 4);
            end
            nxt();
        end
        idle(); nxt();
        // reset with both FIFOs occupied and stage 0 valid
        for (int k = 0; k < 2; k++) begin
            drv(0, 12, 1, 64'hd00 + k, 64'h700, 0);
            drv(1, 13, 1, 64'he00 + k, 64'h800, 0);
            drv(2, 14, 1, 64'hf00 + k, 64'h900, 0);
            nxt();
        end
        idle(); rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", bus.commit_valid, 0);
        chk("rst_mid_ready", bus.in_ready, 0);
        chk("rst_mid_pc", bus.commit_pc, 0);
        nxt();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_valid", bus.commit_valid, 0);
            chk("post_rst_ready", bus.in_ready, 3'b111);
            nxt();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
